rfa_wr_arbiter: RTL
===================

Name: rfa_wr_arbiter

Overview:
- Parametrised write-port arbiter for the VGPR/SGPR execute write-back path; next generation of the single-port RFA arbiter.
- Grants one writer per cycle among NUM_QUEUES ALU result queues (SIMD then SIMF order), the LSU and the SALU.
- Queues use round-robin. SALU beats LSU beats queues, except that starvation counters force a grant to a starved class.
- Drives the one-hot write-source select consumed by the register-file write mux.

Parameters:
NUM_QUEUES, 8, number of ALU result queues (2..14, need not be a power of two)
SEL_W, 16, width of execvgprsgpr_select_fu; must be >= NUM_QUEUES+2
ALU_STARVE_LIMIT, 15, consecutive denied cycles before queues are forced (>=1)
LSU_STARVE_LIMIT, 15, consecutive denied cycles before LSU is forced (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous assert, active-low
queue_valid  in  NUM_QUEUES  per-queue write request; bit i = queue i
lsu_dest_wr_req  in  1  LSU write request
salu_req  in  1  SALU write request
queue_serviced  out  NUM_QUEUES  one-hot queue grant, same cycle as request
lsu_wait  out  1  LSU requested but not granted this cycle
salu_wait  out  1  SALU requested but not granted this cycle
execvgprsgpr_select_fu  out  SEL_W  one-hot select: [NUM_QUEUES-1:0] queues, [NUM_QUEUES] LSU, [NUM_QUEUES+1] SALU, upper bits 0
force_active  out  1  state is FORCE_ALU or FORCE_LSU (debug/perf)

Behaviour:
- Reset (rst=0): rr_ptr=0, alu_cnt=0, lsu_cnt=0, state=NORMAL. All outputs are gated to 0 while rst is low.
- Grant logic is combinational: zero-latency grant in the cycle of the request. At most one select bit is set. No grant when nothing requests.
- Round-robin pick: scan queue_valid starting at rr_ptr upward, wrapping modulo NUM_QUEUES. The first set bit wins.
- rr_ptr updates only on a queue grant: rr_ptr <= (g+1)==NUM_QUEUES ? 0 : g+1. Otherwise it holds.
- State NORMAL:
  - salu_req -> SALU granted.
  - else lsu_dest_wr_req -> LSU granted.
  - else round-robin queue grant.
- State FORCE_ALU:
  - If |queue_valid, a queue is granted; SALU and LSU are denied.
  - Otherwise NORMAL rules apply.
- State FORCE_LSU:
  - If lsu_dest_wr_req, LSU is granted; SALU is denied.
  - Otherwise NORMAL rules apply.
- lsu_wait = lsu_dest_wr_req & ~LSU grant. salu_wait = salu_req & ~SALU grant.
- alu_cnt, per cycle:
  - cleared on a queue grant or when queue_valid==0;
  - else incremented if |queue_valid was denied;
  - saturates at ALU_STARVE_LIMIT.
- lsu_cnt follows the same rules for lsu_dest_wr_req, with LSU_STARVE_LIMIT.
- Counter width is $clog2(limit+1).
- State transitions (registered):
  - NORMAL -> FORCE_ALU when next alu_cnt == ALU_STARVE_LIMIT.
  - else NORMAL -> FORCE_LSU when next lsu_cnt == LSU_STARVE_LIMIT.
  - ALU has precedence when both reach their limits in the same cycle. LSU is forced on the following opportunity, because its counter stays saturated.
  - FORCE_* -> NORMAL after exactly one cycle, whether or not the forced class requested.
- Deassertion of a request in a force cycle is legal. That cycle uses NORMAL arbitration.
- Asynchronous reset during FORCE_* returns to NORMAL with counters cleared. The first cycle after reset release arbitrates from rr_ptr=0.

Decomposition:
- Shared package (rfa_arb_pkg): state encoding (NORMAL=2'd0, FORCE_ALU=2'd1, FORCE_LSU=2'd2) and select-bit offsets (SEL_LSU_OFS=NUM_QUEUES, SEL_SALU_OFS=NUM_QUEUES+1), expressed as localparam functions of NUM_QUEUES.
- One sub-module, rfa_rr_pick, holds the round-robin kernel: rotate by rr_ptr with modulo wrap, priority-encode, un-rotate. Inputs are valid and ptr; outputs are one-hot grant, index and any_valid.

Test Plan:
1. NUM_QUEUES=8; queue_valid=8'hFF held, no LSU/SALU, 10 cycles -> grants queue 0,1,...,7,0,1. rr_ptr wraps 7->0.
2. queue_valid=8'h11 with lsu_dest_wr_req and salu_req both 1 -> select bit 9 (SALU) set, lsu_wait=1, queue_serviced=0, salu_wait=0, rr_ptr unchanged.
3. ALU_STARVE_LIMIT=4; queue_valid=8'h04 and lsu_dest_wr_req held high:
   - cycles 0-3 grant LSU;
   - cycle 4: force_active=1, queue 2 granted, lsu_wait=1;
   - cycle 5: LSU granted again, alu_cnt=1.
4. LSU_STARVE_LIMIT=3; salu_req and lsu_dest_wr_req held -> SALU granted for 3 cycles, then LSU granted for 1 cycle (salu_wait=1). The pattern repeats every 4 cycles.
5. In FORCE_ALU, drop rst for 1 cycle -> all outputs 0 during reset. After release: state NORMAL, counters 0, and with queue_valid=8'h80 the grant is queue 7 and rr_ptr becomes 0.
6. NUM_QUEUES=6 (SEL_W=16); queue_valid=6'b100001 after granting queue 5 -> next grant is queue 0. Select bits [15:8]=0 and LSU grant appears on bit 6.

Source files
------------

// File: rtl/rfa_arb_pkg.sv
// Shared definitions for the RFA write-port arbiter: FSM encoding and the
// select-bit layout helpers, which depend on the number of ALU queues.
package rfa_arb_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        FORCE_ALU = 2'd1,
        FORCE_LSU = 2'd2
    } arb_state_e;

    // LSU select bit sits directly above the queue bits.
    function automatic int sel_lsu_ofs(input int num_queues);
        return num_queues;
    endfunction

    // SALU select bit sits directly above the LSU bit.
    function automatic int sel_salu_ofs(input int num_queues);
        return num_queues + 1;
    endfunction

    // Width of a starvation counter that must hold 0..limit.
    function automatic int cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rfa_wr_arbiter_if.sv
// Request/grant bundle between the write-back requesters and the arbiter.
// The master side drives requests; the slave side (arbiter) drives grants.
interface rfa_wr_if #(
    parameter int NUM_QUEUES = 8,
    parameter int SEL_W      = 16
);
    logic [NUM_QUEUES-1:0] queue_valid;
    logic                  lsu_dest_wr_req;
    logic                  salu_req;
    logic [NUM_QUEUES-1:0] queue_serviced;
    logic                  lsu_wait;
    logic                  salu_wait;
    logic [SEL_W-1:0]      execvgprsgpr_select_fu;
    logic                  force_active;

    modport master (
        output queue_valid, lsu_dest_wr_req, salu_req,
        input  queue_serviced, lsu_wait, salu_wait,
               execvgprsgpr_select_fu, force_active
    );

    modport slave (
        input  queue_valid, lsu_dest_wr_req, salu_req,
        output queue_serviced, lsu_wait, salu_wait,
               execvgprsgpr_select_fu, force_active
    );
endinterface

// File: rtl/rfa_wr_arbiter_rr_pick.sv
// Round-robin kernel: rotate the request vector so rr_ptr lands on bit 0
// (modulo N, N need not be a power of two), take the lowest set bit, then
// map the winner back to its real queue index.
module rfa_rr_pick #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);
    logic [N-1:0] rot;
    logic         found;
    int           src;
    int           off;
    int           win;

    // Rotate, priority-encode and un-rotate in one combinational pass.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        rot       = '0;
        grant     = '0;
        idx       = '0;
        found     = 1'b0;
        src       = 0;
        off       = 0;
        win       = 0;
        any_valid = |valid;
        for (int i = 0; i < N; i++) begin
            src = i + int'(ptr);
            if (src >= N) src = src - N;
            rot[i] = valid[src];
        end
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = i;
            end
        end
        win = off + int'(ptr);
        if (win >= N) win = win - N;
        if (found) begin
            grant[win] = 1'b1;
            idx        = IW'(win);
        end
    end
endmodule

// File: rtl/rfa_wr_arbiter.sv
// Write-port arbiter for the VGPR/SGPR write-back path. One writer per cycle
// among the ALU result queues (round-robin), the LSU and the SALU. Fixed
// priority SALU > LSU > queues, overridden for one cycle when a starvation
// counter saturates.
module rfa_wr_arbiter
    import rfa_arb_pkg::*;
#(
    parameter int NUM_QUEUES       = 8,
    parameter int SEL_W            = 16,
    parameter int ALU_STARVE_LIMIT = 15,
    parameter int LSU_STARVE_LIMIT = 15
) (
    input logic     clk,
    input logic     rst,
    rfa_wr_if.slave bus
);
    localparam int SEL_LSU_OFS  = sel_lsu_ofs(NUM_QUEUES);
    localparam int SEL_SALU_OFS = sel_salu_ofs(NUM_QUEUES);
    localparam int IW           = $clog2(NUM_QUEUES);
    localparam int ACW          = cnt_w(ALU_STARVE_LIMIT);
    localparam int LCW          = cnt_w(LSU_STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ACW-1:0]        alu_cnt_q, alu_cnt_d;
    logic [LCW-1:0]        lsu_cnt_q, lsu_cnt_d;

    logic [NUM_QUEUES-1:0] pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;

    logic [NUM_QUEUES-1:0] gnt_queue;
    logic                  gnt_lsu;
    logic                  gnt_salu;
    logic [SEL_W-1:0]      sel;

    rfa_rr_pick #(.N(NUM_QUEUES)) u_rr_pick (
        .valid     (bus.queue_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Select the single winner for this cycle; a force only applies if the
    // forced class is actually requesting, otherwise normal priority runs.
    always_comb begin
        gnt_queue = '0;
        gnt_lsu   = 1'b0;
        gnt_salu  = 1'b0;
        if (state_q == FORCE_ALU && pick_any) begin
            gnt_queue = pick_grant;
        end else if (state_q == FORCE_LSU && bus.lsu_dest_wr_req) begin
            gnt_lsu = 1'b1;
        end else if (bus.salu_req) begin
            gnt_salu = 1'b1;
        end else if (bus.lsu_dest_wr_req) begin
            gnt_lsu = 1'b1;
        end else begin
            gnt_queue = pick_grant;
        end
    end

    // Next pointer, starvation counters and force state.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        alu_cnt_d = alu_cnt_q;
        lsu_cnt_d = lsu_cnt_q;
        state_d   = NORMAL;

        if (|gnt_queue) begin
            rr_ptr_d = (int'(pick_idx) + 1 == NUM_QUEUES) ? '0 : pick_idx + 1'b1;
        end

        if ((|gnt_queue) || !pick_any) begin
            alu_cnt_d = '0;
        end else if (alu_cnt_q != ACW'(ALU_STARVE_LIMIT)) begin
            alu_cnt_d = alu_cnt_q + 1'b1;
        end

        if (gnt_lsu || !bus.lsu_dest_wr_req) begin
            lsu_cnt_d = '0;
        end else if (lsu_cnt_q != LCW'(LSU_STARVE_LIMIT)) begin
            lsu_cnt_d = lsu_cnt_q + 1'b1;
        end

        // A force lasts one cycle; ALU wins a tie, LSU stays saturated and
        // is forced at the next NORMAL cycle.
        if (state_q == NORMAL) begin
            if (alu_cnt_d == ACW'(ALU_STARVE_LIMIT)) begin
                state_d = FORCE_ALU;
            end else if (lsu_cnt_d == LCW'(LSU_STARVE_LIMIT)) begin
                state_d = FORCE_LSU;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= NORMAL;
            rr_ptr_q  <= '0;
            alu_cnt_q <= '0;
            lsu_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            alu_cnt_q <= alu_cnt_d;
            lsu_cnt_q <= lsu_cnt_d;
        end
    end

    // One-hot select and status outputs, forced low while reset is held.
    always_comb begin
        sel                        = '0;
        sel[NUM_QUEUES-1:0]        = gnt_queue;
        sel[SEL_LSU_OFS]           = gnt_lsu;
        sel[SEL_SALU_OFS]          = gnt_salu;
        bus.execvgprsgpr_select_fu = rst ? sel : '0;
        bus.queue_serviced         = rst ? gnt_queue : '0;
        bus.lsu_wait               = rst & bus.lsu_dest_wr_req & ~gnt_lsu;
        bus.salu_wait              = rst & bus.salu_req & ~gnt_salu;
        bus.force_active           = rst & (state_q != NORMAL);
    end
endmodule
